// File: rtl/instr_prefetch_pkg.sv
// Shared constants for the instruction prefetch stage: default address width,
// memory read latency and the default reset fetch address.
package instr_prefetch_pkg;

  localparam int         BYTE_W           = 8;
  localparam int         ADDR_WIDTH_DEF   = 8;
  localparam int         MEM_READ_LATENCY = 1;
  localparam logic [7:0] RESET_PC_DEF     = 8'h00;

endpackage

// File: rtl/instr_prefetch_fifo.sv
// Synchronous FIFO with single-cycle flush holding {byte, pc} prefetch entries.
// The head entry is presented combinationally from the read pointer.
module instr_prefetch_fifo
  import instr_prefetch_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int W     = 16
) (
  input  logic                       clk,
  input  logic                       resetN,
  input  logic                       i_flush,
  input  logic                       i_push,
  input  logic [W-1:0]               i_push_data,
  input  logic                       i_pop,
  output logic [W-1:0]               o_head,
  output logic [$clog2(DEPTH):0]     o_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [W-1:0]  r_mem [DEPTH];
  logic [PW-1:0] r_rd_ptr;
  logic [PW-1:0] r_wr_ptr;
  logic [CW-1:0] r_count;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (!resetN || i_flush) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (i_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage is not reset; the parent never pushes during reset or flush.
  always_ff @(posedge clk) begin
    if (i_push) r_mem[r_wr_ptr] <= i_push_data;
  end

  assign o_head  = r_mem[r_rd_ptr];
  assign o_count = r_count;

endmodule

// File: rtl/instr_prefetch.sv
// Instruction-byte prefetch: streams sequential bytes from a 1-cycle-latency
// memory into a small FIFO and hands them to the decoder with their PC.
module instr_prefetch
  import instr_prefetch_pkg::*;
#(
  parameter int                    DEPTH      = 4,
  parameter int                    ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = ADDR_WIDTH'(RESET_PC_DEF)
) (
  input  logic                  clk,
  input  logic                  resetN,
  output logic [ADDR_WIDTH-1:0] memAddr,
  output logic                  memStrobe,
  input  logic [BYTE_W-1:0]     memDataRead,
  output logic [BYTE_W-1:0]     outByte,
  output logic [ADDR_WIDTH-1:0] outPc,
  output logic                  outValid,
  input  logic                  outReady,
  input  logic                  redirect,
  input  logic [ADDR_WIDTH-1:0] redirectAddr
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int EW = BYTE_W + ADDR_WIDTH;

  logic [ADDR_WIDTH-1:0] r_fetch_pc;
  logic [ADDR_WIDTH-1:0] r_req_pc;
  logic                  r_in_flight;

  logic [CW-1:0] w_count;
  logic [CW:0]   w_occupancy;
  logic          w_strobe;
  logic          w_push;
  logic          w_pop;
  logic [EW-1:0] w_head;

  // Occupancy counts the outstanding read; a same-cycle pop is not credited,
  // so a full FIFO never sees a push it cannot absorb.
  assign w_occupancy = {1'b0, w_count} + (CW + 1)'(r_in_flight);
  assign w_strobe    = resetN & ~redirect & (w_occupancy < (CW + 1)'(DEPTH));
  assign w_push      = resetN & ~redirect & r_in_flight;
  assign w_pop       = outValid & outReady;

  always_ff @(posedge clk) begin
    if (!resetN) begin
      r_fetch_pc  <= RESET_PC;
      r_req_pc    <= RESET_PC;
      r_in_flight <= 1'b0;
    end else if (redirect) begin
      r_fetch_pc  <= redirectAddr;
      r_in_flight <= 1'b0;
    end else begin
      r_in_flight <= w_strobe;
      if (w_strobe) begin
        r_fetch_pc <= r_fetch_pc + 1'b1;
        r_req_pc   <= r_fetch_pc;
      end
    end
  end

  instr_prefetch_fifo #(
    .DEPTH (DEPTH),
    .W     (EW)
  ) u_fifo (
    .clk         (clk),
    .resetN      (resetN),
    .i_flush     (redirect),
    .i_push      (w_push),
    .i_push_data ({memDataRead, r_req_pc}),
    .i_pop       (w_pop),
    .o_head      (w_head),
    .o_count     (w_count)
  );

  assign memAddr   = r_fetch_pc;
  assign memStrobe = w_strobe;
  assign outValid  = resetN & (w_count != '0) & ~redirect;
  assign outByte   = w_head[ADDR_WIDTH +: BYTE_W];
  assign outPc     = w_head[ADDR_WIDTH-1:0];

endmodule
